// File: rtl/sigmoid_plan_pkg.sv
// -----------------------------------------------------------------------------
// sigmoid_plan_pkg
// Shared definitions for the PLAN sigmoid family: Q16.16 constants, segment
// breakpoints and offsets used by the inverse (logit) approximation, plus
// the segment and FSM state enumerations.
// No ports (package).
// -----------------------------------------------------------------------------
package sigmoid_plan_pkg;

    // Q16.16 constants
    localparam logic [31:0] ONE   = 32'h0001_0000;
    localparam logic [31:0] HALF  = 32'h0000_8000;
    localparam logic [31:0] FIVE  = 32'h0005_0000;

    // Breakpoints on the folded probability m
    localparam logic [31:0] BRK_B = 32'h0000_C000;
    localparam logic [31:0] BRK_C = 32'h0000_EC00;

    // Per-segment offsets subtracted from m before scaling
    localparam logic [31:0] OFF_B = 32'h0000_A000;
    localparam logic [31:0] OFF_C = 32'h0000_D800;

    typedef enum logic [1:0] {
        SEG_A,
        SEG_B,
        SEG_C,
        SEG_D
    } seg_e;

    typedef enum logic [2:0] {
        IDLE,
        FOLD,
        SEG,
        CALC,
        OUT
    } state_e;

endpackage

// File: rtl/sigmoid_inv_plan_seg.sv
// -----------------------------------------------------------------------------
// plan_inv_seg
// Combinational magnitude evaluator for the inverse PLAN approximation.
// Given the folded probability m (>= 0.5) and its segment code, returns |x|.
// Ports:
//   m    in  N  folded probability, unsigned Q16.16
//   seg  in  2  segment code (SEG_A..SEG_D)
//   mag  out N  |x|, unsigned Q16.16, at most 5.0
// -----------------------------------------------------------------------------
module plan_inv_seg
    import sigmoid_plan_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] m,
    input  seg_e         seg,
    output logic [N-1:0] mag
);

    // Piecewise-linear inverse; each subtraction is non-negative within its segment.
    always_comb begin
        mag = N'(FIVE);
        case (seg)
            SEG_A:   mag = (m - N'(HALF))  << 3'd2;
            SEG_B:   mag = (m - N'(OFF_B)) << 3'd3;
            SEG_C:   mag = (m - N'(OFF_C)) << 3'd5;
            SEG_D:   mag = N'(FIVE);
            default: mag = N'(FIVE);
        endcase
    end

endmodule

// File: rtl/sigmoid_inv_plan.sv
// -----------------------------------------------------------------------------
// sigmoid_inv_plan
// Inverse of the PLAN sigmoid approximation: maps a Q16.16 probability y to
// a signed Q16.16 x with PLAN(x) ~= y. Five-state FSM (IDLE, FOLD, SEG,
// CALC, OUT); one operand in flight, result 3 edges after acceptance.
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  operand y present
//   in_ready   out  1  high exactly while the FSM is in IDLE
//   y          in   N  unsigned Q16.16 probability
//   out_valid  out  1  one-cycle pulse, x valid
//   x          out  N  signed Q16.16 result, held until the next result
//   range_err  out  1  only with SIGMOID_INV_RANGE_ERR_EN: y was above 1.0
// Optional feature macro: SIGMOID_INV_RANGE_ERR_EN
// -----------------------------------------------------------------------------
module sigmoid_inv_plan
    import sigmoid_plan_pkg::*;
#(
    parameter int N    = 32,
    parameter int FRAC = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] y,
    output logic         out_valid,
    output logic [N-1:0] x
`ifdef SIGMOID_INV_RANGE_ERR_EN
    ,
    output logic         range_err
`endif
);

    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1} << FRAC;

    state_e       state_q, state_d;
    logic [N-1:0] y_q, y_d;
    logic [N-1:0] m_q, m_d;
    logic         neg_q, neg_d;
    seg_e         seg_q, seg_d;
    logic [N-1:0] x_q, x_d;
    logic         out_valid_q, out_valid_d;
    logic         in_ready_q, in_ready_d;
    logic [N-1:0] mag_s;
`ifdef SIGMOID_INV_RANGE_ERR_EN
    logic         range_err_q, range_err_d;
`endif

    plan_inv_seg #(.N(N)) u_seg (
        .m   (m_q),
        .seg (seg_q),
        .mag (mag_s)
    );

    // Next-state and datapath: fold, classify, evaluate, then pulse the result.
    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        m_d         = m_q;
        neg_d       = neg_q;
        seg_d       = seg_q;
        x_d         = x_q;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b0;
`ifdef SIGMOID_INV_RANGE_ERR_EN
        range_err_d = range_err_q;
`endif
        case (state_q)
            IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone accepts.
                if (in_valid) begin
                    y_d     = y;
                    state_d = FOLD;
`ifdef SIGMOID_INV_RANGE_ERR_EN
                    range_err_d = 1'b0;
`endif
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            FOLD: begin
                // logit(1-p) = -logit(p): evaluate on the upper half only.
                if (y_q < N'(HALF)) begin
                    m_d   = ONE_N - y_q;
                    neg_d = 1'b1;
                end else begin
                    m_d   = y_q;
                    neg_d = 1'b0;
                end
                state_d = SEG;
            end
            SEG: begin
                if (m_q >= ONE_N) begin
                    seg_d = SEG_D;
                end else if (m_q >= N'(BRK_C)) begin
                    seg_d = SEG_C;
                end else if (m_q >= N'(BRK_B)) begin
                    seg_d = SEG_B;
                end else begin
                    seg_d = SEG_A;
                end
                state_d = CALC;
            end
            CALC: begin
                if (neg_q) begin
                    x_d = N'(0) - mag_s;
                end else begin
                    x_d = mag_s;
                end
                out_valid_d = 1'b1;
`ifdef SIGMOID_INV_RANGE_ERR_EN
                range_err_d = (y_q > ONE_N);
`endif
                state_d = OUT;
            end
            OUT: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any operand in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            y_q         <= '0;
            m_q         <= '0;
            neg_q       <= 1'b0;
            seg_q       <= SEG_A;
            x_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef SIGMOID_INV_RANGE_ERR_EN
            range_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            m_q         <= m_d;
            neg_q       <= neg_d;
            seg_q       <= seg_d;
            x_q         <= x_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef SIGMOID_INV_RANGE_ERR_EN
            range_err_q <= range_err_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign x         = x_q;
`ifdef SIGMOID_INV_RANGE_ERR_EN
    assign range_err = range_err_q;
`endif

endmodule

// File: tb/tb_sigmoid_inv_plan.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_inv_plan
// Self-checking bench for sigmoid_inv_plan: directed vectors, latency and
// pulse width, randomized operands against a piecewise-linear logit model,
// back-to-back handshake, and reset behaviour.
// -----------------------------------------------------------------------------
module tb_sigmoid_inv_plan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] y;
    logic        out_valid;
    logic [31:0] x;
`ifdef SIGMOID_INV_RANGE_ERR_EN
    logic        range_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sigmoid_inv_plan #(.N(32), .FRAC(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .x         (x)
`ifdef SIGMOID_INV_RANGE_ERR_EN
        ,
        .range_err (range_err)
`endif
    );

    // Reference logit: lines anchored at known points, odd symmetry about 0.5.
    function automatic logic [31:0] ref_logit(input logic [31:0] yv);
        longint p;
        longint r;
        bit     neg;
        p   = longint'(yv);
        neg = 1'b0;
        if (p < 32768) begin
            p   = 65536 - p;
            neg = 1'b1;
        end
        if (p >= 65536)      r = 5 * 65536;                      // saturate 5.0
        else if (p >= 60416) r = 163840 + 32 * (p - 60416);      // 2.5 at 0.921875
        else if (p >= 49152) r = 65536 + 8 * (p - 49152);        // 1.0 at 0.75
        else                 r = 4 * (p - 32768);                // 0.0 at 0.5
        if (neg) r = -r;
        return r[31:0];
    endfunction

    // Issue one operand and wait (bounded) for its result.
    task automatic run_op(input logic [31:0] yv, output logic [31:0] xo, output int lat);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b1;
        y        = yv;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        xo  = 32'hxxxx_xxxx;
        while (lat < 12) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid === 1'b1) begin
                xo = x;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        y        = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (x !== 32'h0) begin n_fail++; $display("FAIL reset_x: got %h expected 00000000", x); end
        // in_valid held across reset release is taken on the first edge.
        in_valid = 1'b1;
        y        = 32'h0000_C000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL release_accept: in_ready got %b expected 0", in_ready); end
        lat = 0;
        while (lat < 12) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid === 1'b1) break;
        end
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL release_latency: got %0d expected 3", lat); end
        n_tests++; if (x !== 32'h0001_0000) begin n_fail++; $display("FAIL release_x: got %h expected 00010000", x); end
    endtask

    task automatic test_directed();
        logic [31:0] ys   [10];
        logic [31:0] exps [10];
        logic [31:0] xo;
        int          lat;
        ys[0] = 32'h0000_8000; exps[0] = 32'h0000_0000;
        ys[1] = 32'h0000_C000; exps[1] = 32'h0001_0000;
        ys[2] = 32'h0000_4000; exps[2] = 32'hFFFF_0000;
        ys[3] = 32'h0000_F000; exps[3] = 32'h0003_0000;
        ys[4] = 32'h0000_9000; exps[4] = 32'h0000_4000;
        ys[5] = 32'h0001_0000; exps[5] = 32'h0005_0000;
        ys[6] = 32'h0000_0000; exps[6] = 32'hFFFB_0000;
        ys[7] = 32'h0000_EBFF; exps[7] = 32'h0002_5FF8;
        ys[8] = 32'h0000_EC00; exps[8] = 32'h0002_8000;
        ys[9] = 32'h0001_8000; exps[9] = 32'h0005_0000;
        for (int i = 0; i < 10; i++) begin
            run_op(ys[i], xo, lat);
            n_tests++;
            if (xo !== exps[i] || lat != 3) begin
                n_fail++;
                $display("FAIL directed y=%h: got x=%h lat=%0d expected x=%h lat=3", ys[i], xo, lat, exps[i]);
            end
        end
    endtask

    task automatic test_pulse_width();
        logic [31:0] xo;
        int          lat;
        run_op(32'h0000_8000, xo, lat);
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL pulse_latency: got %0d expected 3", lat); end
        @(posedge clk); #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pulse_width: out_valid got %b expected 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pulse_idle: in_ready got %b expected 1", in_ready); end
        n_tests++; if (x !== 32'h0) begin n_fail++; $display("FAIL pulse_hold: x got %h expected 00000000", x); end
    endtask

    task automatic test_random();
        logic [31:0] yv;
        logic [31:0] xo;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) yv = $urandom;
            else                           yv = $urandom_range(0, 32'h0001_0400);
            run_op(yv, xo, lat);
            n_tests++;
            if (xo !== ref_logit(yv) || lat != 3) begin
                n_fail++;
                $display("FAIL random y=%h: got x=%h lat=%0d expected x=%h lat=3", yv, xo, lat, ref_logit(yv));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] yv;
        int          results;
        int          ready_low;
        int          guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        yv        = $urandom_range(0, 32'h0001_0000);
        results   = 0;
        ready_low = 0;
        in_valid  = 1'b1;
        y         = yv;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 11) in_valid = 1'b0;
            if (out_valid === 1'b1) begin
                results++;
                n_tests++;
                if (x !== ref_logit(yv)) begin
                    n_fail++;
                    $display("FAIL b2b_x y=%h: got %h expected %h", yv, x, ref_logit(yv));
                end
            end
            if (in_ready !== 1'b1) ready_low++;
        end
        n_tests++; if (results != 3) begin n_fail++; $display("FAIL b2b_results: got %0d expected 3", results); end
        n_tests++; if (ready_low != 12) begin n_fail++; $display("FAIL b2b_ready_low: got %0d expected 12", ready_low); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] xo;
        int          lat;
        int          seen;
        run_op(32'h0000_F000, xo, lat);
        n_tests++; if (xo !== 32'h0003_0000) begin n_fail++; $display("FAIL mid_pre_x: got %h expected 00030000", xo); end
        @(posedge clk); #1;
        in_valid = 1'b1;
        y        = 32'h0000_9000;
        @(posedge clk); #1;            // now in FOLD
        in_valid = 1'b0;
        @(posedge clk); #1;            // now in SEG
        rst_n = 1'b0;
        #1;
        n_tests++; if (x !== 32'h0) begin n_fail++; $display("FAIL mid_x: got %h expected 00000000", x); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
        seen = (out_valid === 1'b1) ? 1 : 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL mid_no_valid: got %0d pulses expected 0", seen); end
    endtask

`ifdef SIGMOID_INV_RANGE_ERR_EN
    task automatic test_range_err();
        logic [31:0] xo;
        int          lat;
        run_op(32'h0001_8000, xo, lat);
        n_tests++; if (xo !== 32'h0005_0000) begin n_fail++; $display("FAIL range_x: got %h expected 00050000", xo); end
        n_tests++; if (range_err !== 1'b1) begin n_fail++; $display("FAIL range_err_set: got %b expected 1", range_err); end
        run_op(32'h0001_0000, xo, lat);
        n_tests++; if (range_err !== 1'b0) begin n_fail++; $display("FAIL range_err_one: got %b expected 0", range_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_pulse_width();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef SIGMOID_INV_RANGE_ERR_EN
        test_range_err();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
